type_rule_cfg_ctrl: RTL and testbench
=====================================

# type_rule_cfg_ctrl

Configuration controller for the parser's type-lookup rule tables. It accepts 32-bit writes from the control-plane register bus and assembles them into a full `type_rule_t` in a staging buffer. On a commit command it waits for the parser pipeline to report idle, then issues a single-cycle one-hot rule write enable to the addressed lookup stage and rule slot. It sits between the register bus and the `i_rule_wren`/`i_type_rule` inputs of every type-lookup stage.

## Interface
Parameters:
- `STAGE_NUM`, 4: number of lookup stages driven.
- `IDLE_TIMEOUT`, 1024: maximum cycles to wait for parser idle before aborting a commit.
- `CFG_ADDR_WIDTH`, 8: config word-address width.
- `RULE_NUM` and `type_rule_t` come from `parser_pkg`.
- Derived: `WORDS = ceil($bits(type_rule_t)/32)`.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_cfg_valid`  in  1  config write request.
- `o_cfg_ready`  out  1  controller can accept a config write.
- `i_cfg_addr`  in  CFG_ADDR_WIDTH  word address.
- `i_cfg_data`  in  32  write data.
- `i_parser_idle`  in  1  parser pipeline holds no packet in flight.
- `o_rule_wren`  out  STAGE_NUM×RULE_NUM  per-stage rule write enables, packed [stage][rule].
- `o_type_rule`  out  type_rule_t  rule data shared by all stages.
- `o_busy`  out  1  commit in progress.
- `o_err_range`  out  1  sticky: commit named an out-of-range stage or rule.
- `o_err_timeout`  out  1  sticky: commit aborted because the idle timeout expired.
- `o_commit_cnt`  out  16  number of successful commits; wraps.

## Operation
Address map (transfer happens when `i_cfg_valid && o_cfg_ready`):
- Addresses 0..WORDS-1: staging word k holds rule bits [32k+31:32k]. Bits of the last word beyond `$bits(type_rule_t)` are ignored.
- Address WORDS: commit register.
  - data[7:0] = rule index, data[15:8] = stage index.
  - data[16] = delete: the committed rule's `typeRule_valid` is forced to 0.
  - data[17] = clear errors: clears both sticky errors; the command performs no commit.
- Address WORDS+1: also clears both sticky errors.
- Other addresses: accepted and ignored.

The staging buffer persists across commits. Multiple rules can share a common image and differ only by re-written words.

State machine:
- IDLE: `o_cfg_ready` = 1.
  - A commit with stage ≥ STAGE_NUM or rule ≥ RULE_NUM sets `o_err_range` and stays in IDLE.
  - A valid commit latches stage, rule and delete, loads the timeout counter with 0, and moves to WAIT.
- WAIT: `o_cfg_ready` = 0; the counter increments each cycle.
  - If `i_parser_idle` = 1, move to WRITE.
  - Otherwise, when the counter reaches IDLE_TIMEOUT-1, set `o_err_timeout` and return to IDLE with no write.
- WRITE: one cycle.
  - The registered `o_rule_wren[stage][rule]` = 1; all other enable bits = 0.
  - `o_type_rule` = staging image, with valid forced to 0 if delete is set.
  - `o_commit_cnt` increments; the state returns to IDLE.
- `o_busy` = 1 in WAIT and WRITE.
- `o_type_rule` holds its value outside WRITE. Downstream stages sample it only when the enable is high.
- A clear-errors command and a simultaneous error-setting event cannot coincide, because errors set only on an accepted commit or in WAIT. If they somehow coincide, the set wins.

## Timing
- Reset values:
  - State IDLE; `o_cfg_ready` = 1.
  - `o_rule_wren` = 0, `o_type_rule` = 0, `o_busy` = 0.
  - Both errors = 0; `o_commit_cnt` = 0.
  - The staging buffer is cleared to 0.
- Reset during WAIT or WRITE aborts the commit. No enable is issued in the cycle after reset is asserted.
- Staging write at cycle T: the buffer is updated at T+1.
- Commit accepted at T, with `i_parser_idle` = 1 at T+1: state is WAIT at T+1, WRITE at T+2. `o_rule_wren` is high during T+2 only; `o_cfg_ready` returns to 1 at T+3.
- Minimum commit-to-enable latency is 2 cycles. Maximum is IDLE_TIMEOUT+1 cycles, after which a timeout abort occurs instead.
- Timeout: with `i_parser_idle` held 0, `o_err_timeout` rises IDLE_TIMEOUT+1 cycles after the accepting edge, and `o_cfg_ready` = 1 the same cycle.
- `i_parser_idle` is sampled only in WAIT; glitches in other states are ignored.
- `o_commit_cnt` increments in the cycle after WRITE; it wraps 0xFFFF→0.

## Test plan
- **Reset check:** assert reset for 3 cycles. Then `o_cfg_ready` = 1, all other outputs 0; a commit to stage 0, rule 0 with all-zero staging yields an enable with an all-zero rule.
- **Basic commit:** write a full staging image with valid = 1, then commit with data = 0x00000302 (stage 3, rule 2) and `i_parser_idle` = 1. `o_rule_wren[3][2]` pulses for exactly 1 cycle, 2 cycles after acceptance; `o_type_rule` equals the image; `o_commit_cnt` = 1.
- **Wait then commit:** hold `i_parser_idle` = 0 for 10 cycles, then 1. `o_cfg_ready` stays low throughout; the enable fires 1 cycle after idle is sampled high; no error.
- **Timeout:** run with IDLE_TIMEOUT = 16 and idle held 0. `o_err_timeout` = 1 at cycle 17 after acceptance; no enable; the counter is unchanged. A subsequent write to address WORDS+1 clears the error.
- **Range error:** commit with stage = STAGE_NUM, and separately with rule = RULE_NUM. `o_err_range` = 1; no enable; `o_busy` never asserts.
- **Delete and mid-commit reset:** a commit with data[16] = 1 drives the enable with `typeRule_valid` = 0 and all other fields from staging. Asserting reset in WAIT produces no enable afterwards; the state is back to IDLE.

Source files
------------

// File: rtl/type_rule_cfg_ctrl.sv
// Type-rule configuration controller.
// Collects 32-bit register-bus writes into a staging image of one type rule.
// On a commit it waits for the parser to go idle, then writes that image into
// one rule slot of one lookup stage with a single-cycle enable.

package parser_pkg;

  localparam int RULE_NUM = 8;

  typedef struct packed {
    logic        typeRule_valid;
    logic [15:0] typeRule_etherType;
    logic [15:0] typeRule_etherTypeMask;
    logic [7:0]  typeRule_protocol;
    logic [7:0]  typeRule_protocolMask;
    logic [3:0]  typeRule_nextState;
  } type_rule_t;

endpackage

module type_rule_cfg_ctrl
  import parser_pkg::*;
#(
  parameter int STAGE_NUM      = 4,
  parameter int IDLE_TIMEOUT   = 1024,
  parameter int CFG_ADDR_WIDTH = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_cfg_valid,
  output logic                                 o_cfg_ready,
  input  logic [CFG_ADDR_WIDTH-1:0]            i_cfg_addr,
  input  logic [31:0]                          i_cfg_data,
  input  logic                                 i_parser_idle,
  output logic [STAGE_NUM-1:0][RULE_NUM-1:0]   o_rule_wren,
  output type_rule_t                           o_type_rule,
  output logic                                 o_busy,
  output logic                                 o_err_range,
  output logic                                 o_err_timeout,
  output logic [15:0]                          o_commit_cnt
);

  localparam int RULE_BITS = $bits(type_rule_t);
  localparam int WORDS     = (RULE_BITS + 31) / 32;
  localparam int WREN_W    = STAGE_NUM * RULE_NUM;
  localparam int CNT_W     = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t               state;
  logic [RULE_BITS-1:0] stage_bits;
  logic [CNT_W-1:0]     wait_cnt;
  logic [7:0]           lat_stage;
  logic [7:0]           lat_rule;
  logic                 lat_delete;

  logic                 cfg_fire;
  logic                 is_commit;
  logic                 is_errclr_reg;
  logic [7:0]           cmd_rule;
  logic [7:0]           cmd_stage;
  logic                 cmd_delete;
  logic                 cmd_clear;
  logic                 cmd_range_bad;
  logic                 commit_ok;
  logic                 commit_bad;
  logic                 err_clear;
  logic [WORDS-1:0]     word_sel;
  logic [15:0]          wren_idx;
  type_rule_t           write_rule;

  // Decode an accepted bus transfer into staging writes and commit/clear commands
  always_comb begin
    cfg_fire      = i_cfg_valid && o_cfg_ready;
    is_commit     = cfg_fire && (i_cfg_addr == CFG_ADDR_WIDTH'(WORDS));
    is_errclr_reg = cfg_fire && (i_cfg_addr == CFG_ADDR_WIDTH'(WORDS + 1));
    cmd_rule      = i_cfg_data[7:0];
    cmd_stage     = i_cfg_data[15:8];
    cmd_delete    = i_cfg_data[16];
    cmd_clear     = i_cfg_data[17];
    cmd_range_bad = ({24'd0, cmd_stage} >= 32'(STAGE_NUM)) ||
                    ({24'd0, cmd_rule}  >= 32'(RULE_NUM));
    commit_ok     = is_commit && !cmd_clear && !cmd_range_bad;
    commit_bad    = is_commit && !cmd_clear &&  cmd_range_bad;
    err_clear     = is_errclr_reg || (is_commit && cmd_clear);
    for (int k = 0; k < WORDS; k++) begin
      word_sel[k] = cfg_fire && (i_cfg_addr == CFG_ADDR_WIDTH'(k));
    end
  end

  // Staging words; the last word keeps only the bits that belong to the rule
  for (genvar k = 0; k < WORDS; k++) begin : g_stage_word
    localparam int LO = k * 32;
    localparam int HI = ((LO + 32) > RULE_BITS) ? (RULE_BITS - 1) : (LO + 31);

    // Load one staging word when its address is written
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        stage_bits[HI:LO] <= '0;
      end else if (word_sel[k]) begin
        stage_bits[HI:LO] <= i_cfg_data[HI-LO:0];
      end
    end
  end

  // Rule image to publish, with the valid bit dropped for a delete
  always_comb begin
    write_rule = type_rule_t'(stage_bits);
    if (lat_delete) begin
      write_rule.typeRule_valid = 1'b0;
    end
    wren_idx = 16'(lat_stage) * 16'(RULE_NUM) + 16'(lat_rule);
  end

  // Commit sequencer: accept, wait for parser idle (bounded), then pulse one enable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= S_IDLE;
      o_cfg_ready   <= 1'b1;
      o_busy        <= 1'b0;
      o_rule_wren   <= '0;
      o_type_rule   <= '0;
      o_err_range   <= 1'b0;
      o_err_timeout <= 1'b0;
      o_commit_cnt  <= '0;
      wait_cnt      <= '0;
      lat_stage     <= '0;
      lat_rule      <= '0;
      lat_delete    <= 1'b0;
    end else begin
      o_rule_wren <= '0;
      case (state)
        S_IDLE: begin
          if (err_clear) begin
            o_err_range   <= 1'b0;
            o_err_timeout <= 1'b0;
          end
          if (commit_bad) begin
            o_err_range <= 1'b1;
          end
          if (commit_ok) begin
            lat_stage   <= cmd_stage;
            lat_rule    <= cmd_rule;
            lat_delete  <= cmd_delete;
            wait_cnt    <= '0;
            state       <= S_WAIT;
            o_cfg_ready <= 1'b0;
            o_busy      <= 1'b1;
          end
        end

        S_WAIT: begin
          if (i_parser_idle) begin
            state       <= S_WRITE;
            o_type_rule <= write_rule;
            o_rule_wren <= WREN_W'(1) << wren_idx;
          end else if (wait_cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
            o_err_timeout <= 1'b1;
            state         <= S_IDLE;
            o_cfg_ready   <= 1'b1;
            o_busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_WRITE: begin
          state        <= S_IDLE;
          o_cfg_ready  <= 1'b1;
          o_busy       <= 1'b0;
          o_commit_cnt <= o_commit_cnt + 16'd1;
        end

        default: begin
          state       <= S_IDLE;
          o_cfg_ready <= 1'b1;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_type_rule_cfg_ctrl.sv
// Testbench for type_rule_cfg_ctrl.
// Expected rule writes are queued when a commit is issued and compared when
// the controller raises an enable.

module tb_type_rule_cfg_ctrl;
  import parser_pkg::*;

  localparam int STAGE_NUM    = 4;
  localparam int IDLE_TIMEOUT = 16;
  localparam int ADDR_W       = 8;
  localparam int RULE_BITS    = $bits(type_rule_t);
  localparam int WORDS        = (RULE_BITS + 31) / 32;
  localparam int WREN_W       = STAGE_NUM * RULE_NUM;

  typedef struct {
    logic [WREN_W-1:0] wren;
    type_rule_t        rule;
  } expWrite_t;

  logic                               clk;
  logic                               i_rst;
  logic                               i_cfg_valid;
  logic                               o_cfg_ready;
  logic [ADDR_W-1:0]                  i_cfg_addr;
  logic [31:0]                        i_cfg_data;
  logic                               i_parser_idle;
  logic [STAGE_NUM-1:0][RULE_NUM-1:0] o_rule_wren;
  type_rule_t                         o_type_rule;
  logic                               o_busy;
  logic                               o_err_range;
  logic                               o_err_timeout;
  logic [15:0]                        o_commit_cnt;

  int checkCount = 0;
  int errorCount = 0;
  int wrenSeen   = 0;
  logic [15:0] expectedCnt = 16'd0;
  logic [WORDS*32-1:0] modelBuf = '0;
  expWrite_t scoreQ[$];

  type_rule_cfg_ctrl #(
    .STAGE_NUM      (STAGE_NUM),
    .IDLE_TIMEOUT   (IDLE_TIMEOUT),
    .CFG_ADDR_WIDTH (ADDR_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_cfg_valid   (i_cfg_valid),
    .o_cfg_ready   (o_cfg_ready),
    .i_cfg_addr    (i_cfg_addr),
    .i_cfg_data    (i_cfg_data),
    .i_parser_idle (i_parser_idle),
    .o_rule_wren   (o_rule_wren),
    .o_type_rule   (o_type_rule),
    .o_busy        (o_busy),
    .o_err_range   (o_err_range),
    .o_err_timeout (o_err_timeout),
    .o_commit_cnt  (o_commit_cnt)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never finishes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard side: every enable must match the oldest queued commit
  always @(negedge clk) begin
    if (i_rst === 1'b0 && o_rule_wren !== '0) begin
      wrenSeen++;
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected_wren", 64'(o_rule_wren), 64'd0);
      end else begin
        expWrite_t e;
        e = scoreQ.pop_front();
        checkOutput("wren_vec", 64'(o_rule_wren), 64'(e.wren));
        checkOutput("type_rule", 64'(o_type_rule), 64'(e.rule));
      end
    end
  end

  // One bus transfer; returns just after the accepting edge
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    int waitCycles = 0;
    @(negedge clk);
    i_cfg_addr  = addr;
    i_cfg_data  = data;
    i_cfg_valid = 1'b1;
    while (o_cfg_ready !== 1'b1 && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    if (o_cfg_ready !== 1'b1) begin
      checkOutput("cfg_ready_wait", 64'(o_cfg_ready), 64'd1);
      i_cfg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    i_cfg_valid = 1'b0;
    if (int'(addr) < WORDS) modelBuf[int'(addr)*32 +: 32] = data;
  endtask

  function automatic logic [31:0] commitWord(input int stage, input int rule,
                                             input logic del, input logic clr);
    return {14'd0, clr, del, 8'(stage), 8'(rule)};
  endfunction

  // Valid commit: idle held low for idleDelay cycles, then the enable is timed and checked
  task automatic doCommit(input int stage, input int rule, input logic del, input int idleDelay);
    expWrite_t e;
    e.wren = WREN_W'(1) << (stage * RULE_NUM + rule);
    e.rule = type_rule_t'(modelBuf[RULE_BITS-1:0]);
    if (del) e.rule.typeRule_valid = 1'b0;
    scoreQ.push_back(e);
    i_parser_idle = (idleDelay == 0);
    applyStimulus(ADDR_W'(WORDS), commitWord(stage, rule, del, 1'b0));
    for (int i = 0; i < idleDelay; i++) begin
      @(negedge clk);
      checkOutput("wait_ready_wren", {63'd0, o_cfg_ready} | 64'(o_rule_wren), 64'd0);
    end
    if (idleDelay > 0) begin
      @(posedge clk);
      #1;
      i_parser_idle = 1'b1;
    end
    @(negedge clk);
    checkOutput("pre_write_busy_wren", {o_busy, 63'(o_rule_wren)}, {1'b1, 63'd0});
    @(negedge clk);
    checkOutput("write_cycle_pulse", 64'($countones(o_rule_wren)), 64'd1);
    @(negedge clk);
    expectedCnt = expectedCnt + 16'd1;
    checkOutput("post_write_wren", 64'(o_rule_wren), 64'd0);
    checkOutput("post_write_ready_busy", {62'd0, o_cfg_ready, o_busy}, 64'b10);
    checkOutput("commit_cnt", 64'(o_commit_cnt), 64'(expectedCnt));
    checkOutput("rule_hold", 64'(o_type_rule), 64'(e.rule));
    checkOutput("no_errors", {62'd0, o_err_range, o_err_timeout}, 64'd0);
  endtask

  initial begin
    int seenBefore;
    i_rst         = 1'b1;
    i_cfg_valid   = 1'b0;
    i_cfg_addr    = '0;
    i_cfg_data    = '0;
    i_parser_idle = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", 64'(o_cfg_ready), 64'd1);
    checkOutput("reset_wren", 64'(o_rule_wren), 64'd0);
    checkOutput("reset_rule", 64'(o_type_rule), 64'd0);
    checkOutput("reset_flags", {61'd0, o_busy, o_err_range, o_err_timeout}, 64'd0);
    checkOutput("reset_cnt", 64'(o_commit_cnt), 64'd0);
    doCommit(0, 0, 1'b0, 0);

    // Basic commit with full image (valid bit set, junk above the rule width)
    applyStimulus(8'd0, 32'hDEAD_BEEF);
    applyStimulus(8'd1, 32'hFFF1_2345);
    $display("[TB] basic commit stage 3 rule 2");
    doCommit(3, 2, 1'b0, 0);

    // Parser busy for 10 cycles before going idle
    doCommit(1, 6, 1'b0, 10);

    // Timeout abort
    seenBefore = wrenSeen;
    i_parser_idle = 1'b0;
    applyStimulus(ADDR_W'(WORDS), commitWord(2, 1, 1'b0, 1'b0));
    for (int k = 1; k <= IDLE_TIMEOUT; k++) begin
      @(negedge clk);
      checkOutput("timeout_pending", {62'd0, o_cfg_ready, o_err_timeout}, 64'd0);
    end
    @(negedge clk);
    checkOutput("timeout_flag_ready", {61'd0, o_cfg_ready, o_err_timeout, o_busy}, 64'b110);
    checkOutput("timeout_cnt", 64'(o_commit_cnt), 64'(expectedCnt));
    checkOutput("timeout_no_wren", 64'(wrenSeen), 64'(seenBefore));
    applyStimulus(ADDR_W'(WORDS + 1), 32'd0);
    @(negedge clk);
    checkOutput("timeout_cleared", 64'(o_err_timeout), 64'd0);

    // Range errors: stage out of range, then rule out of range
    i_parser_idle = 1'b1;
    applyStimulus(ADDR_W'(WORDS), commitWord(STAGE_NUM, 0, 1'b0, 1'b0));
    repeat (3) begin
      @(negedge clk);
      checkOutput("range_stage_busy_ready", {62'd0, o_busy, o_cfg_ready}, 64'b01);
    end
    checkOutput("range_stage_err", 64'(o_err_range), 64'd1);
    applyStimulus(ADDR_W'(WORDS), commitWord(0, 0, 1'b0, 1'b1));
    @(negedge clk);
    checkOutput("range_clear_cmd", 64'(o_err_range), 64'd0);
    applyStimulus(ADDR_W'(WORDS), commitWord(0, RULE_NUM, 1'b0, 1'b0));
    repeat (3) begin
      @(negedge clk);
      checkOutput("range_rule_busy", 64'(o_busy), 64'd0);
    end
    checkOutput("range_rule_err", 64'(o_err_range), 64'd1);
    checkOutput("range_no_wren", 64'(wrenSeen), 64'(seenBefore));
    applyStimulus(ADDR_W'(WORDS + 1), 32'd0);
    @(negedge clk);
    checkOutput("range_clear_reg", 64'(o_err_range), 64'd0);

    // Delete: valid forced low, other fields from staging
    doCommit(2, 5, 1'b1, 0);

    // A few random images and targets, re-using one staging word each time
    for (int n = 0; n < 4; n++) begin
      applyStimulus(ADDR_W'(n % WORDS), $urandom);
      doCommit($urandom_range(0, STAGE_NUM - 1), $urandom_range(0, RULE_NUM - 1),
               1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    // Reset while waiting for idle aborts the commit
    seenBefore = wrenSeen;
    i_parser_idle = 1'b0;
    applyStimulus(ADDR_W'(WORDS), commitWord(0, 3, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    i_parser_idle = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_state", {61'd0, o_cfg_ready, o_busy, |o_rule_wren}, 64'b100);
    i_rst = 1'b0;
    modelBuf = '0;
    expectedCnt = 16'd0;
    repeat (4) @(negedge clk);
    checkOutput("mid_reset_no_wren", 64'(wrenSeen), 64'(seenBefore));
    checkOutput("mid_reset_cnt", 64'(o_commit_cnt), 64'd0);
    doCommit(1, 7, 1'b0, 0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(scoreQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
